// File: rtl/spawn_scheduler.sv
// spawn_scheduler
//   Turns a free-running pseudorandom word into timed spawn requests. After
//   a random number of frame ticks a request (x position, object type) is
//   presented on a valid/ready handshake and held until it is accepted.
//
//   Optional build macro: SPAWN_COUNT_EN adds spawn_count, a wrapping
//   16-bit count of completed transfers.
//
// Ports
//   clk          system clock, posedge
//   rst_n        synchronous active-low reset
//   en           scheduler enable (game running)
//   frame_tick   one-cycle pulse per video frame
//   rand_word    32-bit pseudorandom word, new value every cycle
//   spawn_valid  spawn request pending
//   spawn_ready  consumer accepts the request this cycle
//   spawn_x      spawn x coordinate (10 bit)
//   spawn_type   object type code (2 bit)
//   spawn_count  completed transfers (SPAWN_COUNT_EN only)
module spawn_scheduler #(
    parameter logic [15:0] MIN_DELAY = 16'd16,
    parameter int          DLY_W     = 6,
    parameter logic [9:0]  X_BASE    = 10'd64,
    parameter int          XW        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_tick,
    input  logic [31:0] rand_word,
    output logic        spawn_valid,
    input  logic        spawn_ready,
    output logic [9:0]  spawn_x,
    output logic [1:0]  spawn_type
`ifdef SPAWN_COUNT_EN
    ,
    output logic [15:0] spawn_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REQ
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [9:0]  x_q, x_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] load_val;
    logic        xfer;

    // Only the delay, x-offset and type fields of the random word are used.
    logic        unused_rand;
    assign unused_rand = ^rand_word;

    assign load_val = MIN_DELAY + 16'(rand_word[DLY_W-1:0]);
    assign xfer     = valid_q & spawn_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        x_d     = x_q;
        type_d  = type_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WAIT;
                    cnt_d   = load_val;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    // countdown is discarded; a fresh delay is drawn on re-enable
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    if (cnt_q != 16'd0) begin
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        state_d = S_REQ;
                        valid_d = 1'b1;
                        // 10-bit add wraps modulo 1024 by construction
                        x_d     = X_BASE + 10'(rand_word[8 +: XW]);
                        type_d  = rand_word[25:24];
                    end
                end
            end
            S_REQ: begin
                // request is held regardless of en/frame_tick until accepted
                if (xfer) begin
                    valid_d = 1'b0;
                    if (en) begin
                        state_d = S_WAIT;
                        cnt_d   = load_val;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            valid_q <= 1'b0;
            x_q     <= 10'd0;
            type_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            type_q  <= type_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_x     = x_q;
    assign spawn_type  = type_q;

`ifdef SPAWN_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (xfer) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign spawn_count = count_q;
`endif

endmodule

// File: tb/tb_spawn_scheduler.sv
module tb_spawn_scheduler;

    localparam logic [15:0] MIN_DELAY = 16'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        frame_tick;
    logic [31:0] rand_word;
    logic        spawn_ready;
    logic        spawn_valid, spawn_valid_w;
    logic [9:0]  spawn_x, spawn_x_w;
    logic [1:0]  spawn_type, spawn_type_w;
`ifdef SPAWN_COUNT_EN
    logic [15:0] spawn_count, spawn_count_w;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spawn_scheduler #(.MIN_DELAY(MIN_DELAY), .DLY_W(2), .X_BASE(10'd64), .XW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_tick(frame_tick), .rand_word(rand_word),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_x(spawn_x),
        .spawn_type(spawn_type)
`ifdef SPAWN_COUNT_EN
        , .spawn_count(spawn_count)
`endif
    );

    // Second instance shares stimulus; only its x base differs (wrap case).
    spawn_scheduler #(.MIN_DELAY(MIN_DELAY), .DLY_W(2), .X_BASE(10'd900), .XW(8)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_tick(frame_tick), .rand_word(rand_word),
        .spawn_valid(spawn_valid_w), .spawn_ready(spawn_ready), .spawn_x(spawn_x_w),
        .spawn_type(spawn_type_w)
`ifdef SPAWN_COUNT_EN
        , .spawn_count(spawn_count_w)
`endif
    );

    // Reference model: ticks still needed before the request, plus flags.
    bit          m_busy, m_pend;
    int          m_left;
    int          m_x, m_xw, m_ty;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_x = 0; m_xw = 0; m_ty = 0; m_cnt = 0;
        end else if (m_pend) begin
            if (spawn_ready) begin
                m_pend = 0;
                m_cnt  = (m_cnt + 1) % 65536;
                m_busy = en;
                if (en) m_left = int'(MIN_DELAY) + int'(rand_word[1:0]) + 1;
            end
        end else if (!m_busy) begin
            if (en) begin
                m_busy = 1;
                m_left = int'(MIN_DELAY) + int'(rand_word[1:0]) + 1;
            end
        end else if (!en) begin
            m_busy = 0;
        end else if (frame_tick) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_pend = 1;
                m_x    = (64 + int'(rand_word[15:8])) % 1024;
                m_xw   = (900 + int'(rand_word[15:8])) % 1024;
                m_ty   = int'(rand_word[25:24]);
            end
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare.
    task automatic step(input logic e, input logic t, input logic r, input logic [31:0] w);
        en = e; frame_tick = t; spawn_ready = r; rand_word = w;
        model_update();
        @(posedge clk);
        #1;
        chk("valid", {31'd0, spawn_valid}, {31'd0, m_pend});
        chk("x", {22'd0, spawn_x}, m_x);
        chk("type", {30'd0, spawn_type}, m_ty);
        chk("valid_w", {31'd0, spawn_valid_w}, {31'd0, m_pend});
        chk("x_w", {22'd0, spawn_x_w}, m_xw);
`ifdef SPAWN_COUNT_EN
        chk("count", {16'd0, spawn_count}, m_cnt);
`endif
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; frame_tick = 1'b1; spawn_ready = 1'b0; rand_word = 32'd0;
        m_left = 0;

        // 1 reset with en/tick active
        step(1, 1, 0, $urandom);
        step(1, 1, 0, $urandom);
        chk("rst_valid", {31'd0, spawn_valid}, 32'd0);
        chk("rst_x", {22'd0, spawn_x}, 32'd0);
        chk("rst_type", {30'd0, spawn_type}, 32'd0);
        rst_n = 1'b1;
        step(0, 1, 0, $urandom);
        chk("idle_quiet", {31'd0, spawn_valid}, 32'd0);

        // 2 timing: load 7, 7 ticks quiet, 8th tick fires
        step(1, 0, 0, 32'h0000_0003);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0, $urandom);
            step(1, 0, 0, $urandom);
        end
        chk("t_quiet", {31'd0, spawn_valid}, 32'd0);
        step(1, 1, 0, 32'h0200_1005);
        chk("t_valid", {31'd0, spawn_valid}, 32'd1);
        chk("t_x", {22'd0, spawn_x}, 32'd80);
        chk("t_type", {30'd0, spawn_type}, 32'd2);

        // 3 backpressure, then accept (reloads since en=1)
        for (int i = 0; i < 5; i++) begin
            step(1, 1'($urandom), 0, $urandom);
            chk("bp_valid", {31'd0, spawn_valid}, 32'd1);
            chk("bp_x", {22'd0, spawn_x}, 32'd80);
            chk("bp_type", {30'd0, spawn_type}, 32'd2);
        end
        step(1, 0, 1, $urandom);
        chk("acc_valid", {31'd0, spawn_valid}, 32'd0);
`ifdef SPAWN_COUNT_EN
        chk("acc_count", {16'd0, spawn_count}, 32'd1);
`endif

        // 4 abort after 3 ticks, then reload 4 and fire on 5th tick
        for (int i = 0; i < 3; i++) step(1, 1, 0, $urandom);
        step(0, 0, 0, $urandom);
        for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), $urandom);
        chk("abort_valid", {31'd0, spawn_valid}, 32'd0);
        step(1, 0, 0, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1, 1, 0, $urandom);
        chk("re_quiet", {31'd0, spawn_valid}, 32'd0);

        // 5 wrap: offset 0xFF at expiry
        step(1, 1, 0, 32'h0100_FF00);
        chk("w_valid", {31'd0, spawn_valid}, 32'd1);
        chk("w_x64", {22'd0, spawn_x}, 32'd319);
        chk("w_x900", {22'd0, spawn_x_w}, 32'd131);
        chk("w_type", {30'd0, spawn_type}, 32'd1);

        // 6 en drop in REQ holds request; accept with en=0 goes idle
        step(0, 1, 0, $urandom);
        step(0, 0, 0, $urandom);
        chk("hold_valid", {31'd0, spawn_valid}, 32'd1);
        step(0, 0, 1, $urandom);
        chk("idle_valid", {31'd0, spawn_valid}, 32'd0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, $urandom);
        chk("no_reload", {31'd0, spawn_valid}, 32'd0);
        // back to REQ, then reset overrides it
        step(1, 0, 0, 32'h0000_0000);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h03FF_FF00);
        chk("req_again", {31'd0, spawn_valid}, 32'd1);
        rst_n = 1'b0;
        step(1, 1, 0, $urandom);
        chk("rst_req_valid", {31'd0, spawn_valid}, 32'd0);
        chk("rst_req_x", {22'd0, spawn_x}, 32'd0);
        rst_n = 1'b1;

        // random phase
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
